// File: rtl/pulse_synth_multi.sv
// Multi-channel pulse synthesiser: debounced step/select buttons with auto-repeat,
// per-channel scale registers, phase-accumulator square waves and a mode-selected combiner.
module pulse_synth_multi #(
    parameter int NUM_CH        = 4,
    parameter int SCALE_W       = 6,
    parameter int SCALE_RESET   = 1,
    parameter int ACC_W         = 24,
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic                                            sysclk,
    input  logic                                            reset,
    input  logic                                            bt_plus,
    input  logic                                            bt_minus,
    input  logic                                            bt_sel,
    input  logic [NUM_CH-1:0]                               enable_sw,
    input  logic [1:0]                                      mode,
    output logic                                            pulse,
    output logic [NUM_CH-1:0]                               pulse_ch,
    output logic [SCALE_W-1:0]                              scale_out,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  ch_sel
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REP_W-1:0]   REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [SCALE_W-1:0] SCALE_MAX = {SCALE_W{1'b1}};

    // button index: 0 = plus, 1 = minus, 2 = sel
    logic [2:0]        btn_meta, btn_sync;
    logic [NUM_CH-1:0] en_meta, en_sync;
    logic [1:0]        mode_meta, mode_sync;

    logic [2:0]        deb_level, deb_prev, step_q;
    logic [DEB_W-1:0]  deb_cnt [3];
    logic [REP_W-1:0]  rep_cnt [2];
    logic [1:0]        rep_hit;

    logic [SCALE_W-1:0] scale [NUM_CH];
    logic [ACC_W-1:0]   acc   [NUM_CH];
    logic               pulse_next;
    logic [NUM_CH-1:0]  ch_masked;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            btn_meta  <= '0;
            btn_sync  <= '0;
            en_meta   <= '0;
            en_sync   <= '0;
            mode_meta <= '0;
            mode_sync <= '0;
        end else begin
            btn_meta  <= {bt_sel, bt_minus, bt_plus};
            btn_sync  <= btn_meta;
            en_meta   <= enable_sw;
            en_sync   <= en_meta;
            mode_meta <= mode;
            mode_sync <= mode_meta;
        end
    end

    always_comb begin
        rep_hit = '0;
        for (int b = 0; b < 2; b++) begin
            rep_hit[b] = deb_level[b] && (rep_cnt[b] == REP_LAST);
        end
    end

    // Step events are registered once more after the level edge, so a press
    // reaches the scale register 2 sync + DEB_CYCLES + 2 cycles after the raw edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            deb_level <= '0;
            deb_prev  <= '0;
            step_q    <= '0;
            for (int b = 0; b < 3; b++) deb_cnt[b] <= '0;
            for (int b = 0; b < 2; b++) rep_cnt[b] <= '0;
        end else begin
            deb_prev <= deb_level;
            step_q   <= (deb_level & ~deb_prev) | {1'b0, rep_hit};
            for (int b = 0; b < 3; b++) begin
                if (btn_sync[b] == deb_level[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DEB_LAST) begin
                    deb_cnt[b]   <= '0;
                    deb_level[b] <= btn_sync[b];
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
                end
            end
            // counting starts the cycle after the initial event so repeats land exactly REPEAT_CYCLES apart
            for (int b = 0; b < 2; b++) begin
                if (!deb_level[b] || rep_hit[b]) begin
                    rep_cnt[b] <= '0;
                end else if (deb_prev[b]) begin
                    rep_cnt[b] <= rep_cnt[b] + REP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            ch_sel <= '0;
            for (int c = 0; c < NUM_CH; c++) scale[c] <= SCALE_W'(SCALE_RESET);
        end else begin
            if (step_q[0] && !step_q[1] && scale[ch_sel] != SCALE_MAX) begin
                scale[ch_sel] <= scale[ch_sel] + SCALE_W'(1);
            end else if (step_q[1] && !step_q[0] && scale[ch_sel] != '0) begin
                scale[ch_sel] <= scale[ch_sel] - SCALE_W'(1);
            end
            if (step_q[2]) begin
                ch_sel <= (ch_sel == CH_LAST) ? '0 : ch_sel + CH_W'(1);
            end
        end
    end

    assign scale_out = scale[ch_sel];

    always_ff @(posedge sysclk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset || !en_sync[c] || scale[c] == '0) begin
                acc[c] <= '0;
            end else begin
                acc[c] <= acc[c] + ACC_W'(scale[c]);
            end
        end
    end

    always_comb begin
        pulse_ch = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pulse_ch[c] = acc[c][ACC_W-1];
        end
    end

    always_comb begin
        ch_masked  = pulse_ch & en_sync;
        pulse_next = 1'b0;
        case (mode_sync)
            2'b00:   pulse_next = |ch_masked;
            2'b01:   pulse_next = ^ch_masked;
            2'b10:   pulse_next = (|en_sync) && (&(pulse_ch | ~en_sync));
            default: pulse_next = pulse_ch[ch_sel];
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            pulse <= 1'b0;
        end else begin
            pulse <= pulse_next;
        end
    end

endmodule

// File: doc/pulse_synth_multi.md
Name: pulse_synth_multi

Overview:
- Parametrised successor to the single-channel pulse generator top.
- Debounces and synchronises the front-panel buttons internally, with auto-repeat while a button is held.
- Keeps an independent frequency scale per channel and runs one phase-accumulator square-wave generator per channel.
- Combines the enabled channels into one pulse output according to a mode input. It sits directly under the board top and drives the output pin and status LEDs.

Parameters:
- NUM_CH, 4: number of channels (2..8).
- SCALE_W, 6: scale register width per channel.
- SCALE_RESET, 1: scale value loaded at reset, every channel.
- ACC_W, 24: phase accumulator width.
- DEB_CYCLES, 500000: consecutive stable cycles needed to accept a button level.
- REPEAT_CYCLES, 12500000: auto-repeat interval while a step button is held.

Ports:
- sysclk  in  1  system clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- bt_plus  in  1  raw button: increase scale of the selected channel.
- bt_minus  in  1  raw button: decrease scale of the selected channel.
- bt_sel  in  1  raw button: advance the selected channel.
- enable_sw  in  NUM_CH  per-channel enable switches (raw, synchronised internally).
- mode  in  2  combine mode for pulse.
- pulse  out  1  combined waveform.
- pulse_ch  out  NUM_CH  per-channel square waves.
- scale_out  out  SCALE_W  scale of the selected channel.
- ch_sel  out  max(1,$clog2(NUM_CH))  selected channel index.

Behaviour:
- Synchronisers:
  - Every raw input (three buttons, enable_sw, mode) passes through a 2-FF synchroniser.
  - The stages reset to 0.
- Debounce, per button:
  - The debounced level changes only after the synchronised level has differed from it for DEB_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A rising edge of the debounced level produces a 1-cycle step event.
- Auto-repeat (plus/minus only):
  - While the debounced level stays high, a further step event fires every REPEAT_CYCLES cycles after the initial event.
  - The repeat counter clears on release.
  - bt_sel has no repeat.
- Scale update, per step event:
  - Applies to scale[ch_sel] and is visible on scale_out the next cycle.
  - Saturates at 0 and at 2^SCALE_W-1; no wrap.
  - Plus and minus events in the same cycle: no change.
- Channel select:
  - A sel event sets ch_sel <= (ch_sel+1) mod NUM_CH.
  - If a sel event and a plus/minus event coincide, the step applies to the old ch_sel.
- Generator, per channel c, each cycle:
  - If enable_sw_sync[c]=0 or scale[c]=0: acc[c] <= 0.
  - Otherwise: acc[c] <= acc[c] + scale[c], zero-extended and modulo 2^ACC_W.
  - pulse_ch[c] = acc[c][ACC_W-1] (a register bit, no extra delay).
  - Output frequency = f_sysclk*scale/2^ACC_W, 50% duty when scale divides 2^ACC_W.
  - A scale change does not reset phase.
- Combine:
  - pulse is registered, 1 cycle after pulse_ch. Let E = pulse_ch masked by enable_sw_sync.
  - mode 00: OR of E.
  - mode 01: XOR of E.
  - mode 10: AND of all enabled bits; 0 if none enabled.
  - mode 11: pulse_ch[ch_sel] regardless of enable (monitor).
- Reset, including mid-operation: synchronous, next edge.
  - All accumulators, pulse, pulse_ch, ch_sel, debounce counters, repeat counters and debounced levels go to 0.
  - All scales go to SCALE_RESET.
  - A button held through reset must re-qualify over DEB_CYCLES before producing an event.
- Latency: raw button edge to scale_out change = 2 sync + DEB_CYCLES + 2 cycles.

Test Plan (NUM_CH=4, SCALE_W=6, ACC_W=8, DEB_CYCLES=4, REPEAT_CYCLES=32):
- Reset: assert reset 2 cycles → pulse=0, pulse_ch=0000, ch_sel=0, scale_out=1. Press plus, then reset mid-debounce → scale_out stays 1.
- Debounce:
  - bt_plus high 3 cycles, low 2, repeated 5× → scale_out stays 1.
  - bt_plus high 20 cycles → scale_out=2 exactly 8 cycles after the edge.
  - bt_plus and bt_minus pressed together → unchanged.
- Saturation and repeat:
  - Hold bt_plus 2200 cycles → scale_out reaches 63 and stays.
  - Hold bt_minus → reaches 0 and stays.
  - Hold bt_plus 100 cycles past qualification from scale 1 → scale_out=5 (initial step plus 3 repeats).
- Channel select: 5 sel presses → ch_sel 1,2,3,0,1. Plus on ch 1 changes only scale[1]; the other scale_out values are unchanged when reselected.
- Frequency:
  - ch0 scale=16, enabled → pulse_ch[0] period 16 cycles, 8 high/8 low.
  - Drop enable → pulse_ch[0]=0 within 3 cycles.
- Mode, with ch0 scale 16 and ch1 scale 32 enabled, others disabled:
  - 00 → OR pattern.
  - 01 → XOR.
  - 10 → AND (high 4 of every 16 cycles).
  - 11 with ch_sel=2 → pulse follows pulse_ch[2]=0.
  - Every pulse is 1 cycle behind pulse_ch.
